// File: rtl/pbus_arbiter_pkg.sv
// Shared widths, state encoding and request payload type for the peripheral-bus arbiter.
package pbus_arbiter_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned BUS_WIDTH        = 32;
  localparam int unsigned BUS_ACC_CNT      = 3;
  localparam int unsigned ACC_W            = $clog2(BUS_ACC_CNT);
  localparam int unsigned PBUS_ARB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_e;

  // Request fields forwarded from the granted master to the slave.
  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic                 w_rb;
    logic [ACC_W-1:0]     acc;
    logic [BUS_WIDTH-1:0] wdata;
  } pbus_req_t;

endpackage

// File: rtl/pbus_arb_watchdog.sv
// Saturating busy-cycle counter; expire flags the last cycle a transaction may stay open.
module pbus_arb_watchdog
  import pbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PBUS_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count busy cycles, restart on each grant, hold at the top value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == CNT_LAST);

endmodule

// File: rtl/pbus_arbiter.sv
// Round-robin two-master arbiter for one peripheral-bus slave port with a response watchdog.
module pbus_arbiter
  import pbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PBUS_ARB_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rstn,
  // master 0 (core load/store)
  input  logic [XLEN-1:0]      m0_addr,
  input  logic                 m0_w_rb,
  input  logic [ACC_W-1:0]     m0_acc,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  input  logic                 m0_req,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  output logic                 m0_resp,
  output logic                 m0_fault,
  // master 1 (DMA / debug)
  input  logic [XLEN-1:0]      m1_addr,
  input  logic                 m1_w_rb,
  input  logic [ACC_W-1:0]     m1_acc,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  input  logic                 m1_req,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 m1_resp,
  output logic                 m1_fault,
  // slave port
  output logic [XLEN-1:0]      p_addr,
  output logic                 p_w_rb,
  output logic [ACC_W-1:0]     p_acc,
  output logic [BUS_WIDTH-1:0] p_wdata,
  output logic                 p_req,
  input  logic [BUS_WIDTH-1:0] p_rdata,
  input  logic                 p_resp,
  input  logic                 p_fault
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       last;
  logic       last_nxt;
  logic       grant;
  logic       expire;
  pbus_req_t  m0_bus;
  pbus_req_t  m1_bus;
  pbus_req_t  req_sel;

  assign m0_bus = '{addr: m0_addr, w_rb: m0_w_rb, acc: m0_acc, wdata: m0_wdata};
  assign m1_bus = '{addr: m1_addr, w_rb: m1_w_rb, acc: m1_acc, wdata: m1_wdata};

  // Busy-cycle watchdog, restarted on every grant.
  pbus_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rstn  (rstn),
    .clear (grant),
    .enable(state != ARB_IDLE),
    .expire(expire)
  );

  // State and last-granted register; reset makes m0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration and transaction-completion transitions.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    grant     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (m0_req && (!m1_req || last)) begin
          state_nxt = ARB_BUSY0;
          last_nxt  = 1'b0;
          grant     = 1'b1;
        end else if (m1_req) begin
          state_nxt = ARB_BUSY1;
          last_nxt  = 1'b1;
          grant     = 1'b1;
        end
      end
      ARB_BUSY0, ARB_BUSY1: begin
        if (p_resp || expire) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Request mux toward the slave and response routing back to the owner;
  // everything is held at zero while reset is asserted so an abort is silent.
  always_comb begin
    logic                 done;
    logic                 rsp_fault;
    logic [BUS_WIDTH-1:0] rsp_data;

    req_sel   = '0;
    p_req     = 1'b0;
    m0_resp   = 1'b0;
    m0_fault  = 1'b0;
    m0_rdata  = '0;
    m1_resp   = 1'b0;
    m1_fault  = 1'b0;
    m1_rdata  = '0;
    done      = p_resp || expire;
    rsp_fault = p_resp ? p_fault : 1'b1;
    rsp_data  = p_resp ? p_rdata : '0;

    if (rstn) begin
      case (state)
        ARB_BUSY0: begin
          req_sel  = m0_bus;
          p_req    = 1'b1;
          m0_resp  = done;
          m0_fault = done && rsp_fault;
          m0_rdata = done ? rsp_data : '0;
        end
        ARB_BUSY1: begin
          req_sel  = m1_bus;
          p_req    = 1'b1;
          m1_resp  = done;
          m1_fault = done && rsp_fault;
          m1_rdata = done ? rsp_data : '0;
        end
        default: ;
      endcase
    end
  end

  assign p_addr  = req_sel.addr;
  assign p_w_rb  = req_sel.w_rb;
  assign p_acc   = req_sel.acc;
  assign p_wdata = req_sel.wdata;

endmodule

// File: tb/tb_pbus_arbiter.sv
// Bench for pbus_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pbus_arbiter;
  import pbus_arbiter_pkg::*;

  localparam int unsigned T     = 4;
  localparam int unsigned OUT_W = 2 + ACC_W + XLEN + BUS_WIDTH + 2 * (2 + BUS_WIDTH);

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [XLEN-1:0]      m0_addr, m1_addr, p_addr;
  logic                 m0_w_rb, m1_w_rb, p_w_rb;
  logic [ACC_W-1:0]     m0_acc, m1_acc, p_acc;
  logic [BUS_WIDTH-1:0] m0_wdata, m1_wdata, p_wdata;
  logic                 m0_req, m1_req, p_req;
  logic [BUS_WIDTH-1:0] m0_rdata, m1_rdata, p_rdata;
  logic                 m0_resp, m1_resp, p_resp;
  logic                 m0_fault, m1_fault, p_fault;
  logic [OUT_W-1:0]     all_out;

  int errors = 0;
  int checks = 0;

  pbus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata), .m0_req(m0_req),
    .m0_rdata(m0_rdata), .m0_resp(m0_resp), .m0_fault(m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata), .m1_req(m1_req),
    .m1_rdata(m1_rdata), .m1_resp(m1_resp), .m1_fault(m1_fault),
    .p_addr(p_addr), .p_w_rb(p_w_rb), .p_acc(p_acc), .p_wdata(p_wdata), .p_req(p_req),
    .p_rdata(p_rdata), .p_resp(p_resp), .p_fault(p_fault)
  );

  always #5 clk = ~clk;

  assign all_out = {p_req, p_w_rb, p_acc, p_addr, p_wdata,
                    m0_resp, m0_fault, m0_rdata, m1_resp, m1_fault, m1_rdata};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_w_rb = 1'b0; m0_acc = '0; m0_wdata = '0; m0_req = 1'b0;
    m1_addr = '0; m1_w_rb = 1'b0; m1_acc = '0; m1_wdata = '0; m1_req = 1'b0;
    p_rdata = '0; p_resp = 1'b0; p_fault = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    step();
    step();
    rstn = 1'b1;
  endtask

  // Move past a response cycle and silence the slave.
  task automatic after_resp();
    step();
    p_resp = 1'b0; p_fault = 1'b0; p_rdata = '0;
  endtask

  // Acts as the slave for one transaction: waits for p_req, answers in the
  // delay-th busy cycle (never, if delay exceeds the timeout) and reports what it saw.
  task automatic serve(input int delay, input logic s_fault, input logic [BUS_WIDTH-1:0] s_data,
                       output int waits, output int busy,
                       output logic r0, output logic r1, output logic f0, output logic f1,
                       output logic [BUS_WIDTH-1:0] d0, output logic [BUS_WIDTH-1:0] d1,
                       output pbus_req_t seen, output bit idle_bad, output bit busy_bad);
    waits = 0; busy = 0; idle_bad = 1'b0; busy_bad = 1'b0;
    r0 = 1'b0; r1 = 1'b0; f0 = 1'b0; f1 = 1'b0; d0 = '0; d1 = '0; seen = '0;
    p_resp = 1'b0; p_fault = 1'b0; p_rdata = '0;
    settle();
    while (p_req !== 1'b1 && waits < 10) begin
      if (all_out !== '0) idle_bad = 1'b1;
      step();
      waits++;
    end
    if (p_req !== 1'b1) begin
      waits = -1;
      return;
    end
    seen = '{addr: p_addr, w_rb: p_w_rb, acc: p_acc, wdata: p_wdata};
    while (busy < 3 * T) begin
      busy++;
      p_resp  = (busy == delay);
      p_fault = p_resp ? s_fault : 1'($urandom);
      p_rdata = p_resp ? s_data : BUS_WIDTH'($urandom);
      settle();
      if (p_req !== 1'b1 || {p_addr, p_w_rb, p_acc, p_wdata} !== seen) busy_bad = 1'b1;
      if (m0_resp === 1'b1 || m1_resp === 1'b1) begin
        r0 = m0_resp; r1 = m1_resp; f0 = m0_fault; f1 = m1_fault; d0 = m0_rdata; d1 = m1_rdata;
        return;
      end
      if ({m0_fault, m0_rdata, m1_fault, m1_rdata} !== '0) busy_bad = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h1234; m1_addr = 32'h5678;
    step();
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    step();
    clear_inputs();
    rstn = 1'b1;
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_release_idle: got %h want 0", all_out); end
  endtask

  task automatic test_single_read();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    m0_addr = 32'h0000_0010; m0_w_rb = 1'b0; m0_acc = 2'd2; m0_wdata = 32'h0; m0_req = 1'b1;
    serve(3, 1'b0, 32'hA5A5_A5A5, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if (waits !== 1) begin errors++; $display("FAIL read_latency: got %0d want 1", waits); end
    checks++; if (busy !== 3) begin errors++; $display("FAIL read_busy_cycles: got %0d want 3", busy); end
    checks++; if ({r0, r1} !== 2'b10) begin errors++; $display("FAIL read_resp: got %b want 10", {r0, r1}); end
    checks++; if (d0 !== 32'hA5A5_A5A5 || f0 !== 1'b0) begin errors++; $display("FAIL read_data: got %h/%b want a5a5a5a5/0", d0, f0); end
    checks++; if (seen.addr !== 32'h10 || seen.w_rb !== 1'b0 || seen.acc !== 2'd2) begin errors++; $display("FAIL read_fields: got %h want 00000010/0/2", seen); end
    checks++; if (ib || bb) begin errors++; $display("FAIL read_clean: got idle_bad=%0d busy_bad=%0d want 0/0", ib, bb); end
    m0_req = 1'b0;
    after_resp();
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL read_post_idle: got %h want 0", all_out); end
  endtask

  task automatic test_round_robin();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    apply_reset();
    m0_addr = 32'h100; m1_addr = 32'h200; m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1 + (i % 2), 1'b0, 32'(i), waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
      checks++; if (waits !== 1) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %0d want 1", i, waits); end
      checks++; if ({r0, r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_order[%0d]: got %b", i, {r0, r1}); end
      checks++; if (seen.addr !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin errors++; $display("FAIL rr_addr[%0d]: got %h", i, seen.addr); end
      after_resp();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  task automatic test_write_mirror();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    m0_addr = 32'hFFFF_0000; m0_w_rb = 1'b0; m0_acc = 2'd1; m0_wdata = 32'h1111_2222; m0_req = 1'b0;
    m1_addr = 32'h0000_0104; m1_w_rb = 1'b1; m1_acc = 2'd2; m1_wdata = 32'hDEAD_BEEF; m1_req = 1'b1;
    serve(2, 1'b0, 32'h0, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if (seen !== pbus_req_t'{addr: 32'h104, w_rb: 1'b1, acc: 2'd2, wdata: 32'hDEAD_BEEF}) begin errors++; $display("FAIL write_mirror: got %h want 104/1/2/deadbeef", seen); end
    checks++; if ({r0, r1, f1} !== 3'b010) begin errors++; $display("FAIL write_resp: got %b want 010", {r0, r1, f1}); end
    checks++; if (ib || bb) begin errors++; $display("FAIL write_clean: got idle_bad=%0d busy_bad=%0d want 0/0", ib, bb); end
    m1_req = 1'b0;
    after_resp();
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL write_idle_zero: got %h want 0", all_out); end
  endtask

  task automatic test_slave_fault();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    clear_inputs();
    m0_addr = 32'h20; m0_req = 1'b1;
    serve(1, 1'b1, 32'h0000_1234, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if ({r0, f0, r1, f1} !== 4'b1100) begin errors++; $display("FAIL fault_flag: got %b want 1100", {r0, f0, r1, f1}); end
    checks++; if (d0 !== 32'h1234) begin errors++; $display("FAIL fault_data: got %h want 00001234", d0); end
    after_resp();
    serve(2, 1'b0, 32'h0000_5678, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if ({r0, f0} !== 2'b10 || d0 !== 32'h5678) begin errors++; $display("FAIL fault_next_clean: got %b/%h want 10/00005678", {r0, f0}, d0); end
    m0_req = 1'b0;
    after_resp();
  endtask

  task automatic test_timeout();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    clear_inputs();
    m1_addr = 32'h300; m1_req = 1'b1;
    serve(100, 1'b0, 32'hFFFF_FFFF, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if (busy !== int'(T)) begin errors++; $display("FAIL timeout_cycle: got %0d want %0d", busy, T); end
    checks++; if ({r0, r1, f1} !== 3'b011 || d1 !== '0) begin errors++; $display("FAIL timeout_resp: got %b/%h want 011/0", {r0, r1, f1}, d1); end
    m1_req = 1'b0;
    step();
    p_resp = 1'b1; p_fault = 1'b1; p_rdata = 32'hCAFE_F00D;
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL late_resp_ignored: got %h want 0", all_out); end
    step();
    p_resp = 1'b0; p_fault = 1'b0; p_rdata = '0;
    // p_resp arriving on the very last allowed cycle beats the watchdog
    m0_addr = 32'h40; m0_req = 1'b1;
    serve(int'(T), 1'b0, 32'h55AA_55AA, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if ({r0, f0} !== 2'b10 || d0 !== 32'h55AA_55AA) begin errors++; $display("FAIL timeout_precedence: got %b/%h want 10/55aa55aa", {r0, f0}, d0); end
    m0_req = 1'b0;
    after_resp();
  endtask

  task automatic test_reset_mid();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    clear_inputs();
    m0_addr = 32'h50; m0_req = 1'b1;
    step();
    settle();
    checks++; if (p_req !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got p_req=%b want 1", p_req); end
    rstn = 1'b0; p_resp = 1'b1; p_rdata = 32'h9999_9999;
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL mid_reset_silent: got %h want 0", all_out); end
    step();
    rstn = 1'b1; p_resp = 1'b0; p_rdata = '0; m1_addr = 32'h60; m1_req = 1'b1;
    settle();
    checks++; if (all_out !== '0) begin errors++; $display("FAIL mid_reset_idle: got %h want 0", all_out); end
    serve(1, 1'b0, 32'h7, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
    checks++; if ({r0, r1} !== 2'b10 || waits !== 1) begin errors++; $display("FAIL mid_reset_m0_first: got %b/%0d want 10/1", {r0, r1}, waits); end
    m0_req = 1'b0; m1_req = 1'b0;
    after_resp();
    step();
  endtask

  // Randomized traffic; the model keeps pending requests per master and the
  // previous winner, and predicts owner, completion cycle, fault and data.
  task automatic test_random();
    int waits, busy; logic r0, r1, f0, f1; logic [BUS_WIDTH-1:0] d0, d1; pbus_req_t seen; bit ib, bb;
    pbus_req_t req_m[2];
    bit        pend[2];
    int        model_last, winner, delay, exp_busy;
    logic      sf, exp_fault;
    logic [BUS_WIDTH-1:0] sd, exp_data;
    apply_reset();
    model_last = 1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    req_m[0] = '0; req_m[1] = '0;
    for (int n = 0; n < 40; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
          pend[m] = 1'b1;
          req_m[m] = '{addr: XLEN'($urandom), w_rb: 1'($urandom), acc: ACC_W'($urandom_range(0, 2)), wdata: BUS_WIDTH'($urandom)};
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[1] = 1'b1;
        req_m[1] = '{addr: XLEN'($urandom), w_rb: 1'($urandom), acc: ACC_W'($urandom_range(0, 2)), wdata: BUS_WIDTH'($urandom)};
      end
      m0_addr = req_m[0].addr; m0_w_rb = req_m[0].w_rb; m0_acc = req_m[0].acc; m0_wdata = req_m[0].wdata; m0_req = pend[0];
      m1_addr = req_m[1].addr; m1_w_rb = req_m[1].w_rb; m1_acc = req_m[1].acc; m1_wdata = req_m[1].wdata; m1_req = pend[1];
      winner    = (pend[0] && pend[1]) ? 1 - model_last : (pend[0] ? 0 : 1);
      delay     = int'($urandom_range(1, T + 1));
      sf        = 1'($urandom);
      sd        = BUS_WIDTH'($urandom);
      exp_busy  = (delay > int'(T)) ? int'(T) : delay;
      exp_fault = (delay > int'(T)) ? 1'b1 : sf;
      exp_data  = (delay > int'(T)) ? '0 : sd;
      serve(delay, sf, sd, waits, busy, r0, r1, f0, f1, d0, d1, seen, ib, bb);
      checks++; if (waits !== 1) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want 1", n, waits); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", n, busy, exp_busy); end
      checks++; if ({r0, r1} !== ((winner == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_owner[%0d]: got %b want m%0d", n, {r0, r1}, winner); end
      checks++; if (seen !== req_m[winner]) begin errors++; $display("FAIL rnd_fields[%0d]: got %h want %h", n, seen, req_m[winner]); end
      checks++; if (((winner == 0) ? f0 : f1) !== exp_fault) begin errors++; $display("FAIL rnd_fault[%0d]: got %b want %b", n, (winner == 0) ? f0 : f1, exp_fault); end
      checks++; if (((winner == 0) ? d0 : d1) !== exp_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n, (winner == 0) ? d0 : d1, exp_data); end
      checks++; if (((winner == 0) ? {f1, d1} : {f0, d0}) !== '0) begin errors++; $display("FAIL rnd_other_quiet[%0d]: got %b/%h want 0", n, (winner == 0) ? f1 : f0, (winner == 0) ? d1 : d0); end
      checks++; if (ib || bb) begin errors++; $display("FAIL rnd_clean[%0d]: got idle_bad=%0d busy_bad=%0d want 0/0", n, ib, bb); end
      model_last   = winner;
      pend[winner] = 1'b0;
      after_resp();
      if (winner == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_mirror();
    test_slave_fault();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pbus_arbiter.md
# pbus_arbiter

Two-master arbiter sharing one peripheral-bus slave port (e.g. an EIC wrapper or other `p_*` peripheral) between the core load/store port (m0) and a second requester such as DMA or debug (m1). Grants the bus round-robin, holds the grant for one complete req/resp transaction, and routes the response back to the granting master. A watchdog terminates any transaction the slave does not answer within a bounded time and flags a fault.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before forced termination; must be ≥1.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `mN_addr`  in  `XLEN`  byte address, N∈{0,1}.
- `mN_w_rb`  in  1  1=write, 0=read.
- `mN_acc`  in  `$clog2(BUS_ACC_CNT)`  access size.
- `mN_wdata`  in  `BUS_WIDTH`  write data.
- `mN_req`  in  1  request, level.
- `mN_rdata`  out  `BUS_WIDTH`  read data, valid with `mN_resp`.
- `mN_resp`  out  1  one-cycle completion pulse.
- `mN_fault`  out  1  fault, valid with `mN_resp`.
- `p_addr`, `p_w_rb`, `p_acc`, `p_wdata`, `p_req`  out  as above  to slave.
- `p_rdata`  in  `BUS_WIDTH`; `p_resp`  in  1; `p_fault`  in  1  from slave.

## Operation
- Master handshake: master raises `mN_req` with stable addr/w_rb/acc/wdata and holds all of them until the cycle `mN_resp`=1. A new request may be presented the next cycle.
- States: IDLE, BUSY0, BUSY1. Register `last` (1 bit) records the last granted master.
- IDLE: no request → stay. Only m0 → BUSY0. Only m1 → BUSY1. Both → grant `~last`. On grant, set `last` to the granted index and clear the counter.
- BUSYn: `p_*` request fields = mn fields combinationally, `p_req`=1. Counter increments each cycle.
  - `p_resp`=1 → `mn_resp`=1, `mn_rdata`=`p_rdata`, `mn_fault`=`p_fault` in the same cycle; next state IDLE.
  - Otherwise, counter == `TIMEOUT_CYCLES`-1 → `mn_resp`=1, `mn_fault`=1, `mn_rdata`=0; next state IDLE. `p_resp` takes precedence if it arrives in the same cycle.
- IDLE drives all `p_*` outputs to 0. The non-granted master sees resp/fault/rdata = 0.
- A `p_resp` in IDLE (late answer after a timeout) is ignored. No master sees it.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, saturating, never wraps.

## Timing
- Reset (`rstn`=0 at a clk edge): state IDLE, `last`=1 (m0 wins the first tie), counter 0. Every output is 0 from the following cycle.
- Reset mid-transaction aborts it silently: no resp to the master. The slave must share the same reset.
- Arbitration latency: one cycle. Request sampled in IDLE at edge k gives `p_req`=1 during cycle k+1.
- Minimum transaction: `p_resp` in the first BUSY cycle, giving 2 cycles from `mN_req` to `mN_resp`.
- The slave sees `p_req` drop the cycle after `p_resp`. The slave must not respond twice.
- Back-to-back throughput: one IDLE cycle between transactions, so a new grant occurs at best every 2 cycles.
- Timeout: `mN_resp`+fault in the `TIMEOUT_CYCLES`-th BUSY cycle.
- All outputs are combinational from state plus inputs. There are no outputs to inputs loops within the arbiter.

## Structure
- Default `PBUS_ARB_TIMEOUT`, the IDLE/BUSY0/BUSY1 localparam encoding and the port widths derive from the shared `femto.vh` macros (`XLEN`, `BUS_WIDTH`, `BUS_ACC_CNT`). Add only the `PBUS_ARB_TIMEOUT` define there.
- Sub-module `pbus_arb_watchdog` contains the saturating counter:
  - inputs: clear, enable
  - output: expire
  - parameter: `TIMEOUT_CYCLES`
- The FSM, `last` register and muxes stay in `pbus_arbiter`.

## Test plan
- Single read: m0 read at 0x0000_0010, slave answers after 3 cycles with 0xA5A5_A5A5 → `p_req` 1 cycle after `m0_req`, `m0_resp`=1 with that data, `m1_resp` stays 0.
- Simultaneous requests after reset, both held → grants in order m0, m1, m0, m1. One IDLE cycle separates each transaction.
- Writes: m1 write 0xDEAD_BEEF to 0x0000_0104 while m0 is idle → `p_addr`, `p_wdata` and `p_w_rb` exactly mirror m1 during BUSY1. Zeros on `p_*` in IDLE.
- Slave fault: `p_fault`=1 with `p_resp` → `m0_fault`=1 for one cycle, and the next transaction is fault-free.
- Timeout, `TIMEOUT_CYCLES`=4, slave silent: `m1_resp`=1 and `m1_fault`=1 in the 4th BUSY cycle. A late `p_resp` one cycle later produces no master response.
- `rstn` pulled low during BUSY0: no `m0_resp`; all outputs 0. After release, simultaneous requests grant m0 first.
